// File: rtl/cpu_pkg.sv
// Shared CPU micro-op definitions: control-bus bit indices, MBR FSM encoding
// and the command decode used by the memory buffer register unit.
package cpu_pkg;

    localparam int CTRL_W     = 16;
    localparam int PC_INC_BIT = 0;
    localparam int MAR_LD_BIT = 1;
    localparam int IR_LD_BIT  = 2;
    localparam int MEM_RD_BIT = 3;
    localparam int MEM_WR_BIT = 4;
    localparam int LD_ACC_BIT = 5;
    localparam int ACC_LD_BIT = 6;
    localparam int ALU_EN_BIT = 7;
    localparam int BR_LD_BIT  = 8;

    localparam logic [CTRL_W-1:0] MBR_CMD_MASK = (16'd1 << MEM_RD_BIT)
                                               | (16'd1 << MEM_WR_BIT)
                                               | (16'd1 << LD_ACC_BIT);

    typedef enum logic [1:0] {
        MBR_IDLE = 2'd0,
        MBR_REQ  = 2'd1,
        MBR_DONE = 2'd2
    } mbr_state_e;

    typedef struct packed {
        logic rd;
        logic wr;
        logic ld;
    } mbr_cmd_t;

    // Read beats write, any memory command beats an accumulator load.
    function automatic mbr_cmd_t decode_mbr_cmd(input logic rd_bit,
                                                input logic wr_bit,
                                                input logic ld_bit);
        mbr_cmd_t cmd;
        cmd.rd = rd_bit;
        cmd.wr = wr_bit & ~rd_bit;
        cmd.ld = ld_bit & ~rd_bit & ~wr_bit;
        return cmd;
    endfunction

endpackage

// File: rtl/mbr_unit_if.sv
// Memory-side request/acknowledge bus of the MBR unit.
interface mbr_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Saturating wait-cycle counter; flags the wait cycle on which the access
// would time out.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);
    localparam int                CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on a new access, otherwise count up to the cap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_CAP)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = inc_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mbr_unit.sv
// Memory buffer register: issues one memory read/write per command, holds the
// MBR value for the BR load path and reports completion or timeout.
module mbr_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] control_signals,
    input  logic [ADDR_W-1:0] mar_addr,
    input  logic [DATA_W-1:0] acc_data,
    mbr_unit_if.master        mem,
    output logic [DATA_W-1:0] mbr2br,
    output logic              busy,
    output logic              done,
    output logic              err
);
    mbr_state_e        state_q;
    logic [DATA_W-1:0] mbr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              req_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    mbr_cmd_t          cmd_s;
    logic              start_s;
    logic              tmr_inc_s;
    logic              expire_s;
    logic              unused_ctrl_s;

    // Command decode and wait-timer control.
    always_comb begin
        cmd_s     = decode_mbr_cmd(control_signals[MEM_RD_BIT],
                                   control_signals[MEM_WR_BIT],
                                   control_signals[LD_ACC_BIT]);
        start_s   = (state_q == MBR_IDLE) && (cmd_s.rd || cmd_s.wr);
        tmr_inc_s = (state_q == MBR_REQ) && !mem.mem_ack;
    end

    assign unused_ctrl_s = ^(control_signals & ~MBR_CMD_MASK);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (start_s),
        .inc_i    (tmr_inc_s),
        .expire_o (expire_s)
    );

    // Access sequencer with registered bus and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MBR_IDLE;
            mbr_q   <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                MBR_IDLE: begin
                    if (cmd_s.rd || cmd_s.wr) begin
                        addr_q  <= mar_addr;
                        we_q    <= cmd_s.wr;
                        if (cmd_s.wr) begin
                            wdata_q <= mbr_q;
                        end
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= MBR_REQ;
                    end else if (cmd_s.ld) begin
                        mbr_q <= acc_data;
                    end
                end
                MBR_REQ: begin
                    // An ack on the last wait cycle still wins over the timeout.
                    if (mem.mem_ack) begin
                        if (!we_q) begin
                            mbr_q <= mem.mem_rdata;
                        end
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= MBR_DONE;
                    end else if (expire_s) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= MBR_DONE;
                    end
                end
                MBR_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= MBR_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= MBR_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mbr2br        = mbr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: doc/mbr_unit.md
MBR_UNIT -- requirements
Module: mbr_unit

Interface
REQ-001 Parameters, SHALL be: ADDR_W default 8, memory address width; DATA_W default 16, data width; TIMEOUT default 15, max wait cycles for mem_ack.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 control_signals  in  16  CPU micro-op bus; bit3=MEM_RD, bit4=MEM_WR, bit5=LD_ACC (MBR<-acc_data); other bits ignored.
REQ-005 mar_addr  in  ADDR_W  address from MAR.
REQ-006 acc_data  in  DATA_W  accumulator value for LD_ACC.
REQ-007 mem_req  out  1  memory request, registered.
REQ-008 mem_we  out  1  1=write, 0=read; valid while mem_req=1.
REQ-009 mem_addr  out  ADDR_W  latched address; valid while mem_req=1.
REQ-010 mem_wdata  out  DATA_W  latched write data; valid while mem_req=1.
REQ-011 mem_rdata  in  DATA_W  read data, valid when mem_ack=1.
REQ-012 mem_ack  in  1  one-cycle memory completion strobe.
REQ-013 mbr2br  out  DATA_W  MBR contents, feeds BR load path.
REQ-014 busy  out  1  1 whenever state != IDLE.
REQ-015 done  out  1  one-cycle pulse on successful access completion.
REQ-016 err  out  1  one-cycle pulse on timeout.

Function
REQ-017 FSM states SHALL be IDLE, REQ, DONE.
REQ-018 Commands SHALL be sampled only in IDLE; control_signals ignored in REQ and DONE.
REQ-019 IDLE, MEM_RD=1: latch mar_addr, mem_we<=0, mem_req<=1, clear wait counter, go REQ.
REQ-020 IDLE, MEM_WR=1, MEM_RD=0: latch mar_addr and current MBR into mem_wdata, mem_we<=1, mem_req<=1, go REQ.
REQ-021 IDLE, MEM_RD=1 and MEM_WR=1 together: read SHALL win, write dropped, no err.
REQ-022 IDLE, LD_ACC=1 with neither MEM_RD nor MEM_WR: MBR<=acc_data at that edge, stay IDLE, no done pulse.
REQ-023 LD_ACC together with MEM_RD or MEM_WR: memory command wins, LD_ACC dropped.
REQ-024 REQ: mem_req, mem_we, mem_addr, mem_wdata SHALL hold stable until exit.
REQ-025 REQ, mem_ack=1 on edge: read -> MBR<=mem_rdata; write -> MBR unchanged; mem_req<=0, done<=1, go DONE.
REQ-026 REQ, mem_ack=0: wait counter +1; counter reaching TIMEOUT with no ack -> mem_req<=0, err<=1, MBR unchanged, go DONE.
REQ-027 Ack on the same edge the counter would reach TIMEOUT SHALL count as success, not timeout.
REQ-028 DONE SHALL last exactly one cycle then return to IDLE; done/err high only during DONE.
REQ-029 mem_ack sampled in IDLE or DONE SHALL be ignored.
REQ-030 Latency: command edge N -> mem_req high cycle N+1; ack sampled at edge M -> mbr2br and done valid cycle M+1; minimum read latency 2 cycles, back-to-back access every 3 cycles.
REQ-031 mbr2br SHALL be the MBR register directly, no combinational path from mem_rdata.
REQ-032 Wait counter width SHALL be clog2(TIMEOUT+1), never wraps.

Reset
REQ-033 rst_n low SHALL force state IDLE, MBR=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, busy=0, counter=0, regardless of clk.
REQ-034 Reset mid-REQ SHALL drop mem_req immediately and abandon the access; no done/err after release.

Structure
REQ-035 Control-bit indices (MEM_RD, MEM_WR, LD_ACC, BR load bit8) and the state encoding SHALL live in a shared cpu_pkg package, alongside other micro-op constants.
REQ-036 The block SHALL be one module; the wait timer MAY be a sub-module mem_wait_timer.

Verification
REQ-037 Read: mar_addr=8'h12, MEM_RD pulse, mem_ack 3 cycles later with mem_rdata=16'hBEEF -> mem_req high 3 cycles, mbr2br=16'hBEEF and done=1 one cycle after ack.
REQ-038 Write: LD_ACC with acc_data=16'h1234, then MEM_WR at mar_addr=8'h40 -> mem_we=1, mem_addr=8'h40, mem_wdata=16'h1234, done on ack, mbr2br stays 16'h1234.
REQ-039 Timeout: MEM_RD, never ack, TIMEOUT=15 -> mem_req drops after 15 wait cycles, err pulse, mbr2br unchanged, busy=0 next cycle.
REQ-040 Simultaneous: MEM_RD|MEM_WR|LD_ACC in one cycle -> read only, mem_we=0, acc_data not loaded; MEM_RD during REQ ignored.
REQ-041 Reset: rst_n low while mem_req=1 -> mem_req=0 asynchronously, mbr2br=0, no done/err after release; late ack ignored.
REQ-042 Boundary: ack on the 15th wait cycle -> done=1, err=0, data loaded.
